dma_copy_engine: RTL and testbench
==================================

Name: dma_copy_engine

Overview:
- Single-channel memory-to-memory copy engine; the master driving the arbiter's DMA-side Membus port, which has lower priority than the CPU.
- Copies LEN words from SRC to DST. Each word is one read transaction followed by one write transaction.
- At most one transaction is outstanding at a time, matching the arbiter's single-outstanding request/response protocol.

Parameters:
- ADDR_WIDTH, 32, byte-address width of the memory bus.
- DATA_WIDTH, 32, data word width; must be a power of two and at least 8.
- LEN_WIDTH, 16, width of the word-count field.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising edge of clk.
- start  in  1  one-cycle command strobe; accepted only in IDLE.
- src_addr  in  ADDR_WIDTH  source byte address; sampled at accepted start.
- dst_addr  in  ADDR_WIDTH  destination byte address; sampled at accepted start.
- len  in  LEN_WIDTH  number of words to copy; sampled at accepted start.
- busy  out  1  high from the cycle after an accepted start until DONE is left.
- done  out  1  one-cycle pulse when the copy completes.
- m_valid  out  1  bus request valid.
- m_ready  in  1  bus request accepted; a fire is m_valid && m_ready.
- m_addr  out  ADDR_WIDTH  bus request address.
- m_wen  out  1  bus request write enable.
- m_wdata  out  DATA_WIDTH  bus write data.
- m_wmask  out  DATA_WIDTH/8  byte write mask.
- m_rvalid  in  1  response valid; returned for both reads and writes.
- m_rdata  in  DATA_WIDTH  read response data.

Behaviour:
- Reset is synchronous, active-low on rst; the always_ff is sensitive to posedge clk only.
- Reset values: state IDLE, busy 0, done 0, m_valid 0, m_wen 0, m_addr 0, m_wdata 0, m_wmask 0, all internal counters and buffers 0.
- Alignment: at start, the low log2(DATA_WIDTH/8) bits of src_addr and dst_addr are forced to 0. Addresses advance by DATA_WIDTH/8 per word and wrap modulo 2^ADDR_WIDTH.
- State machine: IDLE -> RD_REQ -> RD_WAIT -> WR_REQ -> WR_WAIT -> (RD_REQ | DONE) -> IDLE.
- IDLE:
  - start=1 latches aligned src, dst and len.
  - len != 0 -> RD_REQ; len = 0 -> DONE with no bus traffic.
  - start is ignored in every other state.
- RD_REQ:
  - m_valid=1, m_wen=0, m_addr=cur_src, m_wmask=0.
  - On fire -> RD_WAIT.
  - m_valid is held and the request fields stay stable until fire. The request is never withdrawn, whatever the state of m_ready.
- RD_WAIT:
  - m_valid=0.
  - On m_rvalid, capture m_rdata into the word buffer -> WR_REQ.
- WR_REQ:
  - m_valid=1, m_wen=1, m_addr=cur_dst, m_wdata=buffer, m_wmask=all ones.
  - Fields stay stable until fire; on fire -> WR_WAIT.
- WR_WAIT:
  - m_valid=0.
  - On m_rvalid: decrement remaining, advance cur_src and cur_dst.
  - Go to DONE if remaining was 1, else RD_REQ.
- DONE: done=1 for exactly one cycle, busy=1; next state is IDLE.
- Output timing:
  - m_valid and the request fields are driven combinationally from state and registers only, with no path from m_ready.
  - m_rvalid is ignored outside the two WAIT states.
  - m_rvalid is only considered on the cycle after a fire, never on the fire cycle itself.
- Throughput with zero-stall memory (ready=1, rvalid one cycle after fire): 4 cycles per word. Done rises 4*len+1 cycles after the start cycle; for len=0, the cycle after start.
- Counter width: remaining is LEN_WIDTH bits. len = 2^LEN_WIDTH-1 is supported with no overflow.
- Reset mid-operation: the next edge with rst=0 returns the block to IDLE with m_valid=0. Any in-flight response is discarded; the arbiter is reset on the same rst.
- A start in the same cycle as a reset is dropped.

Test Plan:
- Zero-stall copy: src=0x100, dst=0x200, len=3, memory holds {0xA,0xB,0xC} -> writes 0xA@0x200, 0xB@0x204, 0xC@0x208, all wmask=0xF; done pulses exactly 13 cycles after start; busy falls with done.
- Backpressure: m_ready held low 5 cycles during RD_REQ and 3 cycles during WR_REQ -> m_valid, m_addr, m_wdata are constant across the stall; exactly one fire per request; the data copied is correct.
- Response latency: rvalid is delayed 7 cycles after each fire, and a spurious rvalid is injected while in RD_REQ -> the spurious pulse is ignored; the copy completes correctly; there is never more than one outstanding request.
- len=0 and unaligned input: start with len=0 -> done the next cycle with no m_valid. Then src=0x103, dst=0x206, len=1 -> read at 0x100, write at 0x204.
- Start ignored while busy and wrap: start asserted mid-copy with different args -> the copy is unaffected. A copy from src=0xFFFFFFFC with len=2 -> second read at 0x00000000.
- Reset mid-copy: rst=0 for one cycle during WR_WAIT of word 2 of 4 -> next cycle busy=0, m_valid=0, no done. A fresh start then performs a complete copy.

Source files
------------

// File: rtl/dma_copy_engine_if.sv
// -----------------------------------------------------------------------------
// dma_copy_engine_if
//
// Membus request/response bundle between the DMA copy engine (master) and the
// arbiter's DMA-side port (slave). The protocol allows one request in flight at
// a time. A request fires on m_valid && m_ready. Every fired request (read or
// write) is answered by exactly one m_rvalid pulse on a later cycle.
//
// Signals:
//   m_valid   master -> slave  request valid
//   m_ready   slave  -> master request accepted this cycle
//   m_addr    master -> slave  byte address of the request
//   m_wen     master -> slave  1 = write, 0 = read
//   m_wdata   master -> slave  write data
//   m_wmask   master -> slave  byte-lane write mask
//   m_rvalid  slave  -> master response valid (reads and writes)
//   m_rdata   slave  -> master read response data
// -----------------------------------------------------------------------------
interface dma_copy_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    m_valid;
  logic                    m_ready;
  logic [ADDR_WIDTH-1:0]   m_addr;
  logic                    m_wen;
  logic [DATA_WIDTH-1:0]   m_wdata;
  logic [DATA_WIDTH/8-1:0] m_wmask;
  logic                    m_rvalid;
  logic [DATA_WIDTH-1:0]   m_rdata;

  modport master (
    output m_valid,
    output m_addr,
    output m_wen,
    output m_wdata,
    output m_wmask,
    input  m_ready,
    input  m_rvalid,
    input  m_rdata
  );

  modport slave (
    input  m_valid,
    input  m_addr,
    input  m_wen,
    input  m_wdata,
    input  m_wmask,
    output m_ready,
    output m_rvalid,
    output m_rdata
  );

endinterface

// File: rtl/dma_copy_engine.sv
// -----------------------------------------------------------------------------
// dma_copy_engine
//
// Single-channel memory-to-memory copy engine. It copies len words from
// src_addr to dst_addr over the Membus. Each word is one read followed by one
// write, and only one transaction is outstanding at any time.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       synchronous reset, active low
//   start     one-cycle command strobe, honoured only while idle
//   src_addr  source byte address (low bits forced to word alignment)
//   dst_addr  destination byte address (low bits forced to word alignment)
//   len       number of words to copy (0 completes immediately)
//   busy      high from the cycle after an accepted start until DONE is left
//   done      one-cycle completion pulse
//   bus       Membus master port (see dma_copy_engine_if)
// -----------------------------------------------------------------------------
module dma_copy_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  dma_copy_engine_if.master     bus
);

  localparam int BYTES = DATA_WIDTH / 8;

  // Address increment per word, and a mask that clears the byte-offset bits.
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BYTES - 1));
  localparam logic [LEN_WIDTH-1:0]  ONE        = LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE
  } state_t;

  state_t                state_reg,     state_next;
  logic [ADDR_WIDTH-1:0] cur_src_reg,   cur_src_next;
  logic [ADDR_WIDTH-1:0] cur_dst_reg,   cur_dst_next;
  logic [LEN_WIDTH-1:0]  remaining_reg, remaining_next;
  logic [DATA_WIDTH-1:0] word_reg,      word_next;

  // State and datapath registers. Reset has priority, so a start that
  // coincides with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      cur_src_reg   <= '0;
      cur_dst_reg   <= '0;
      remaining_reg <= '0;
      word_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      cur_src_reg   <= cur_src_next;
      cur_dst_reg   <= cur_dst_next;
      remaining_reg <= remaining_next;
      word_reg      <= word_next;
    end
  end

  // Next-state and output logic. The request outputs depend only on the
  // registered state and datapath. m_ready steers only the next state, so
  // there is no combinational path from m_ready to m_valid. m_rvalid is
  // looked at only in the two WAIT states. Those states are entered on the
  // cycle after a fire, so an rvalid on the fire cycle is never seen.
  always_comb begin
    state_next     = state_reg;
    cur_src_next   = cur_src_reg;
    cur_dst_next   = cur_dst_reg;
    remaining_next = remaining_reg;
    word_next      = word_reg;

    bus.m_valid    = 1'b0;
    bus.m_wen      = 1'b0;
    bus.m_addr     = '0;
    bus.m_wdata    = '0;
    bus.m_wmask    = '0;

    busy           = (state_reg != S_IDLE);
    done           = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          cur_src_next   = src_addr & ALIGN_MASK;
          cur_dst_next   = dst_addr & ALIGN_MASK;
          remaining_next = len;
          // A zero-length copy completes without any bus traffic.
          state_next     = (len == '0) ? S_DONE : S_RD_REQ;
        end
      end

      S_RD_REQ: begin
        bus.m_valid = 1'b1;
        bus.m_addr  = cur_src_reg;
        if (bus.m_ready) begin
          state_next = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        if (bus.m_rvalid) begin
          word_next  = bus.m_rdata;
          state_next = S_WR_REQ;
        end
      end

      S_WR_REQ: begin
        bus.m_valid = 1'b1;
        bus.m_wen   = 1'b1;
        bus.m_addr  = cur_dst_reg;
        bus.m_wdata = word_reg;
        bus.m_wmask = '1;
        if (bus.m_ready) begin
          state_next = S_WR_WAIT;
        end
      end

      S_WR_WAIT: begin
        if (bus.m_rvalid) begin
          // Addresses wrap naturally at the address width.
          remaining_next = remaining_reg - ONE;
          cur_src_next   = cur_src_reg + STEP;
          cur_dst_next   = cur_dst_reg + STEP;
          // Compare the pre-decrement count so that a full-scale len never
          // needs a wider counter.
          state_next     = (remaining_reg == ONE) ? S_DONE : S_RD_REQ;
        end
      end

      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
module tb_dma_copy_engine;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic        busy;
  logic        done;

  dma_copy_engine_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dma_copy_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory as seen by the bus slave, and the reference copy of memory that
  // the model updates. Untouched words read as a fixed hash of the address.
  logic [31:0] bus_mem   [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
  endfunction

  // Slave knobs: stall < 0 means random stall 0..3; lat == 0 means random 1..4.
  int rd_stall = 0;
  int wr_stall = 0;
  int lat      = 1;
  bit spurious_en = 1'b0;

  logic [31:0] obs_rd[$], obs_wa[$], obs_wd[$];
  logic [3:0]  obs_wm[$];
  logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$];
  int          valid_cycles = 0;

  // Behavioural memory slave. It samples the bus at the falling edge and
  // drives its responses 1 time unit after the rising edge.
  initial begin
    bit          pending = 1'b0;
    int          cd = 0;
    int          age = 0;
    int          stall_tgt = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] pend_data = '0;
    logic [31:0] h_addr = '0;
    logic [31:0] h_wdata = '0;
    logic        h_wen = 1'b0;
    logic [3:0]  h_wmask = '0;
    bus.m_ready  = 1'b0;
    bus.m_rvalid = 1'b0;
    bus.m_rdata  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pending    = 1'b0;
        age        = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_hold_valid", bus.m_valid, 1'b1);
          chk("stall_hold_addr",  bus.m_addr,  h_addr);
          chk("stall_hold_wen",   bus.m_wen,   h_wen);
          chk("stall_hold_wdata", bus.m_wdata, h_wdata);
          chk("stall_hold_wmask", bus.m_wmask, h_wmask);
        end
        if (bus.m_valid) valid_cycles++;
        if (bus.m_valid && bus.m_ready) begin
          chk("single_outstanding", pending, 1'b0);
          if (bus.m_wen) begin
            bus_mem[bus.m_addr] = bus.m_wdata;
            obs_wa.push_back(bus.m_addr);
            obs_wd.push_back(bus.m_wdata);
            obs_wm.push_back(bus.m_wmask);
            pend_data = $urandom;
          end else begin
            pend_data = bus_rd(bus.m_addr);
            obs_rd.push_back(bus.m_addr);
          end
          pending = 1'b1;
          cd      = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
          age     = 0;
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        h_addr  = bus.m_addr;
        h_wen   = bus.m_wen;
        h_wdata = bus.m_wdata;
        h_wmask = bus.m_wmask;
      end
      @(posedge clk);
      #1;
      bus.m_rvalid = 1'b0;
      bus.m_rdata  = $urandom;
      if (pending) begin
        cd--;
        if (cd == 0) begin
          bus.m_rvalid = 1'b1;
          bus.m_rdata  = pend_data;
          pending      = 1'b0;
        end
      end else if (spurious_en && bus.m_valid && !bus.m_wen) begin
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'hBAD0BAD0;
      end
      if (bus.m_valid) begin
        if (age == 0) begin
          if (bus.m_wen) stall_tgt = (wr_stall < 0) ? int'($urandom_range(0, 3)) : wr_stall;
          else           stall_tgt = (rd_stall < 0) ? int'($urandom_range(0, 3)) : rd_stall;
        end
        bus.m_ready = (age >= stall_tgt);
        age++;
      end else begin
        bus.m_ready = 1'b0;
        age = 0;
      end
    end
  end

  // Reference model: a plain word-by-word copy over the model memory.
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] a = s & 32'hFFFF_FFFC;
    logic [31:0] b = d & 32'hFFFF_FFFC;
    logic [31:0] v;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    for (int i = 0; i < n; i++) begin
      v = model_mem.exists(a) ? model_mem[a] : init_word(a);
      model_mem[b] = v;
      exp_rd.push_back(a);
      exp_wa.push_back(b);
      exp_wd.push_back(v);
      a = a + 32'd4;
      b = b + 32'd4;
    end
  endtask

  // One full copy: issue start, wait (bounded) for done, then compare the bus
  // traffic with the model. exp_lat < 0 skips the latency check; inject_at > 0
  // pulses a second start with different arguments at that cycle.
  task automatic run_copy(input string name, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] n, input int exp_lat, input int inject_at);
    int cyc = 0;
    bit got = 1'b0;
    model_copy(s, d, int'(n));
    obs_rd.delete(); obs_wa.delete(); obs_wd.delete(); obs_wm.delete();
    valid_cycles = 0;
    @(posedge clk); #1;
    start = 1'b1; src_addr = s; dst_addr = d; len = n;
    @(negedge clk);
    chk({name, ":busy_on_start_cycle"}, busy, 1'b0);
    @(posedge clk); #1;
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom; len = 16'($urandom);
    for (int i = 1; i <= 4000 && !got; i++) begin
      @(negedge clk);
      if (i == 1) chk({name, ":busy_after_start"}, busy, 1'b1);
      if (i == inject_at) begin
        start = 1'b1; src_addr = 32'h0000_7000; dst_addr = 32'h0000_7800; len = 16'd5;
      end else if (i == inject_at + 1) begin
        start = 1'b0;
      end
      if (done) begin
        got = 1'b1;
        cyc = i;
      end
    end
    start = 1'b0;
    chk({name, ":done_seen"}, got, 1'b1);
    if (exp_lat >= 0) chk({name, ":done_latency"}, cyc, exp_lat);
    chk({name, ":busy_with_done"}, busy, 1'b1);
    @(negedge clk);
    chk({name, ":done_one_cycle"}, done, 1'b0);
    chk({name, ":busy_falls"}, busy, 1'b0);
    chk({name, ":num_reads"},  obs_rd.size(), exp_rd.size());
    chk({name, ":num_writes"}, obs_wa.size(), exp_wa.size());
    if (n == 0) chk({name, ":no_valid"}, valid_cycles, 0);
    for (int i = 0; i < exp_rd.size(); i++) begin
      if (i < obs_rd.size()) chk($sformatf("%s:rd_addr[%0d]", name, i), obs_rd[i], exp_rd[i]);
      if (i < obs_wa.size()) begin
        chk($sformatf("%s:wr_addr[%0d]", name, i), obs_wa[i], exp_wa[i]);
        chk($sformatf("%s:wr_data[%0d]", name, i), obs_wd[i], exp_wd[i]);
        chk($sformatf("%s:wr_mask[%0d]", name, i), obs_wm[i], 4'hF);
      end
    end
    $display("copy %s src=0x%08h dst=0x%08h len=%0d done_after=%0d writes=%0d",
             name, s, d, n, cyc, obs_wa.size());
  endtask

  initial begin
    bit done_seen;
    rst = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset:busy",    busy,        1'b0);
    chk("reset:done",    done,        1'b0);
    chk("reset:m_valid", bus.m_valid, 1'b0);
    chk("reset:m_wen",   bus.m_wen,   1'b0);
    chk("reset:m_addr",  bus.m_addr,  32'h0);
    chk("reset:m_wdata", bus.m_wdata, 32'h0);
    chk("reset:m_wmask", bus.m_wmask, 4'h0);

    // A start that arrives together with reset must be dropped.
    @(posedge clk); #1;
    start = 1'b1; src_addr = 32'h500; dst_addr = 32'h600; len = 16'd2;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("start_in_reset:busy",    busy,        1'b0);
      chk("start_in_reset:m_valid", bus.m_valid, 1'b0);
    end

    // Zero-stall copy of three known words.
    bus_mem[32'h100] = 32'hA; model_mem[32'h100] = 32'hA;
    bus_mem[32'h104] = 32'hB; model_mem[32'h104] = 32'hB;
    bus_mem[32'h108] = 32'hC; model_mem[32'h108] = 32'hC;
    run_copy("zero_stall", 32'h100, 32'h200, 16'd3, 13, -1);

    // Backpressure: 5 stall cycles per read request, 3 per write request.
    rd_stall = 5; wr_stall = 3;
    run_copy("backpressure", 32'h1000, 32'h1800, 16'd3, 37, -1);

    // Slow responses plus spurious rvalid pulses during read requests.
    rd_stall = 2; wr_stall = 0; lat = 7; spurious_en = 1'b1;
    run_copy("latency", 32'h2000, 32'h2800, 16'd3, 55, -1);
    rd_stall = 0; lat = 1; spurious_en = 1'b0;

    // Zero length, then unaligned addresses.
    run_copy("len0", 32'h300, 32'h400, 16'd0, 1, -1);
    run_copy("unaligned", 32'h103, 32'h206, 16'd1, 5, -1);

    // A second start mid-copy is ignored; source addresses wrap.
    run_copy("start_ignored", 32'h3000, 32'h3800, 16'd4, 17, 6);
    run_copy("wrap", 32'hFFFF_FFFC, 32'h5000, 16'd2, 9, -1);

    // Overlapping regions: each read sees the word written just before it.
    run_copy("overlap", 32'h8000, 32'h8004, 16'd4, 17, -1);

    // Reset during the write response of word 2 of 4.
    lat = 7;
    model_copy(32'h6000, 32'h6800, 2);
    obs_rd.delete(); obs_wa.delete(); obs_wd.delete(); obs_wm.delete();
    @(posedge clk); #1;
    start = 1'b1; src_addr = 32'h6000; dst_addr = 32'h6800; len = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 400 && obs_wa.size() < 2; i++) @(negedge clk);
    chk("rst_mid:reached_word2_write", obs_wa.size(), 2);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid:busy",    busy,        1'b0);
    chk("rst_mid:m_valid", bus.m_valid, 1'b0);
    done_seen = done;
    repeat (30) begin
      @(negedge clk);
      done_seen |= done;
    end
    chk("rst_mid:no_done",    done_seen,     1'b0);
    chk("rst_mid:no_more_rd", obs_rd.size(), 2);
    chk("rst_mid:no_more_wr", obs_wa.size(), 2);
    lat = 1;
    run_copy("after_reset", 32'h6000, 32'h6800, 16'd4, 17, -1);

    // Randomized copies with random stalls and latencies.
    rd_stall = -1; wr_stall = -1; lat = 0;
    for (int k = 0; k < 6; k++) begin
      run_copy($sformatf("random%0d", k),
               32'h0001_0000 + $urandom_range(0, 1023),
               32'h0002_0000 + $urandom_range(0, 1023),
               16'($urandom_range(1, 8)), -1, (k % 2 == 1) ? 3 : -1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
